// File: rtl/coriolis_pkg.sv
`default_nettype none
// Shared FloPoCo word definitions for the coriolis kernel datapath.
package coriolis_pkg;

  localparam int FPC_W = 34;

  localparam logic [1:0] FPC_EXC_ZERO   = 2'b00;
  localparam logic [1:0] FPC_EXC_NORMAL = 2'b01;
  localparam logic [1:0] FPC_EXC_INF    = 2'b10;
  localparam logic [1:0] FPC_EXC_NAN    = 2'b11;

  typedef logic [FPC_W-1:0] fpc_word_t;

  function automatic logic [1:0] fpc_exc(input fpc_word_t w);
    return w[FPC_W-1 -: 2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/coriolis_sync_fifo_fwft.sv
`default_nettype none
// First-word-fall-through synchronous FIFO; the head word is visible on dout
// one cycle after it is pushed. The caller must never push when full or pop when empty.
module coriolis_sync_fifo_fwft #(
  parameter int STREAMW = 34,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [STREAMW-1:0]       din,
  output logic [STREAMW-1:0]       dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int ADDRW = $clog2(DEPTH);
  localparam logic [ADDRW:0] FULL_COUNT = (ADDRW+1)'(DEPTH);

  logic [STREAMW-1:0] mem_q [DEPTH];
  logic [ADDRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDRW:0]     count_q, count_d;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/coriolis_ker1_subker1_join2.sv
`default_nettype none
// Two-input stream join: pairs word k of in1 with word k of in2 behind
// per-input elastic FIFOs and presents them under a single valid/ready handshake.
module coriolis_ker1_subker1_join2
  import coriolis_pkg::*;
#(
  parameter int STREAMW = FPC_W,
  parameter int DEPTH   = 4,
  parameter int ADDRW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid_in1,
  input  logic [STREAMW-1:0] in1,
  output logic               iready_in1,
  input  logic               ivalid_in2,
  input  logic [STREAMW-1:0] in2,
  output logic               iready_in2,
  output logic               ovalid,
  output logic [STREAMW-1:0] out1,
  output logic [STREAMW-1:0] out2,
  input  logic               oready
);

  localparam logic [ADDRW:0] FULL_COUNT = (ADDRW+1)'(DEPTH);

  logic               push1, push2, pop;
  logic [STREAMW-1:0] dout1, dout2;
  logic [ADDRW:0]     count1, count2;
  logic               full1, full2, empty1, empty2;

  // Ready comes from registered FIFO state only, so oready never reaches iready.
  assign iready_in1 = ~rst & ~full1;
  assign iready_in2 = ~rst & ~full2;
  assign push1      = ivalid_in1 & iready_in1;
  assign push2      = ivalid_in2 & iready_in2;

  assign ovalid = ~rst & ~empty1 & ~empty2;
  assign pop    = ovalid & oready;
  assign out1   = ovalid ? dout1 : '0;
  assign out2   = ovalid ? dout2 : '0;

  coriolis_sync_fifo_fwft #(
    .STREAMW (STREAMW),
    .DEPTH   (DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .pop   (pop),
    .din   (in1),
    .dout  (dout1),
    .count (count1),
    .full  (full1),
    .empty (empty1)
  );

  coriolis_sync_fifo_fwft #(
    .STREAMW (STREAMW),
    .DEPTH   (DEPTH)
  ) u_fifo2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push2),
    .pop   (pop),
    .din   (in2),
    .dout  (dout2),
    .count (count2),
    .full  (full2),
    .empty (empty2)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count1 <= FULL_COUNT);
      assert (count2 <= FULL_COUNT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coriolis_ker1_subker1_join2.sv
`default_nettype none
// Bench for the two-input join: directed vector table plus queue scoreboard.
module tb_coriolis_ker1_subker1_join2;

  localparam int W = 34;
  localparam int D = 4;
  localparam logic [W-1:0] A_BASE = 34'h1_43D8_0000;
  localparam logic [W-1:0] B_BASE = 34'h1_3F80_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ivalid_in1 = 1'b0, ivalid_in2 = 1'b0, oready = 1'b0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic         iready_in1, iready_in2, ovalid;
  logic [W-1:0] out1, out2;

  always #5 clk = ~clk;

  coriolis_ker1_subker1_join2 #(.STREAMW(W), .DEPTH(D), .ADDRW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .ivalid_in1 (ivalid_in1),
    .in1        (in1),
    .iready_in1 (iready_in1),
    .ivalid_in2 (ivalid_in2),
    .in2        (in2),
    .iready_in2 (iready_in2),
    .ovalid     (ovalid),
    .out1       (out1),
    .out2       (out2),
    .oready     (oready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int npairs   = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];

  typedef struct {
    logic         r, v1, v2, ordy;
    logic [W-1:0] d1, d2;
    logic         e_ov, e_ir1, e_ir2;
    logic [W-1:0] e_o1, e_o2;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic logic [W-1:0] A(input int k);
    return A_BASE + W'(k);
  endfunction

  function automatic logic [W-1:0] B(input int k);
    return B_BASE + W'(k);
  endfunction

  function automatic vec_t V(input logic r, input logic v1, input logic [W-1:0] d1,
                             input logic v2, input logic [W-1:0] d2, input logic ordy,
                             input logic e_ov, input logic [W-1:0] e_o1,
                             input logic [W-1:0] e_o2, input logic e_ir1, input logic e_ir2);
    vec_t t;
    t.r = r; t.v1 = v1; t.d1 = d1; t.v2 = v2; t.d2 = d2; t.ordy = ordy;
    t.e_ov = e_ov; t.e_o1 = e_o1; t.e_o2 = e_o2; t.e_ir1 = e_ir1; t.e_ir2 = e_ir2;
    return t;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic v1, input logic [W-1:0] d1,
                       input logic v2, input logic [W-1:0] d2, input logic ordy);
    @(negedge clk);
    rst = r; ivalid_in1 = v1; in1 = d1; ivalid_in2 = v2; in2 = d2; oready = ordy;
    #1;
  endtask

  task automatic mcycle(input string tag, input logic r, input logic v1, input logic [W-1:0] d1,
                        input logic v2, input logic [W-1:0] d2, input logic ordy);
    logic eov, eir1, eir2;
    drive(r, v1, d1, v2, d2, ordy);
    eov  = !r && (q1.size() > 0) && (q2.size() > 0);
    eir1 = !r && (q1.size() < D);
    eir2 = !r && (q2.size() < D);
    check({tag, " ovalid"},     W'(ovalid),     W'(eov));
    check({tag, " iready_in1"}, W'(iready_in1), W'(eir1));
    check({tag, " iready_in2"}, W'(iready_in2), W'(eir2));
    if (eov) begin
      check({tag, " out1"}, out1, q1[0]);
      check({tag, " out2"}, out2, q2[0]);
    end else begin
      check({tag, " out1 masked"}, out1, '0);
      check({tag, " out2 masked"}, out2, '0);
    end
    if (r) begin
      q1.delete();
      q2.delete();
    end else begin
      if (eov && ordy) begin
        void'(q1.pop_front());
        void'(q2.pop_front());
        npairs++;
      end
      if (v1 && eir1) q1.push_back(d1);
      if (v2 && eir2) q2.push_back(d2);
    end
  endtask

  initial begin
    // Reset, idle, skew fill, refused push, first pair, mid-stream reset.
    tbl[0]  = V(1, 0, '0,   0, '0,   0, 0, '0,   '0,   0, 0);
    tbl[1]  = V(1, 0, '0,   0, '0,   0, 0, '0,   '0,   0, 0);
    tbl[2]  = V(1, 0, '0,   0, '0,   0, 0, '0,   '0,   0, 0);
    tbl[3]  = V(0, 0, '0,   0, '0,   0, 0, '0,   '0,   1, 1);
    tbl[4]  = V(0, 1, A(0), 0, '0,   0, 0, '0,   '0,   1, 1);
    tbl[5]  = V(0, 1, A(1), 0, '0,   0, 0, '0,   '0,   1, 1);
    tbl[6]  = V(0, 1, A(2), 0, '0,   0, 0, '0,   '0,   1, 1);
    tbl[7]  = V(0, 1, A(3), 0, '0,   0, 0, '0,   '0,   1, 1);
    tbl[8]  = V(0, 1, A(4), 0, '0,   0, 0, '0,   '0,   0, 1);
    tbl[9]  = V(0, 0, '0,   1, B(0), 0, 0, '0,   '0,   0, 1);
    tbl[10] = V(0, 0, '0,   0, '0,   0, 1, A(0), B(0), 0, 1);
    tbl[11] = V(0, 0, '0,   0, '0,   1, 1, A(0), B(0), 0, 1);
    tbl[12] = V(0, 0, '0,   1, B(1), 1, 0, '0,   '0,   1, 1);
    tbl[13] = V(0, 0, '0,   0, '0,   1, 1, A(1), B(1), 1, 1);
    tbl[14] = V(0, 1, A(5), 0, '0,   0, 0, '0,   '0,   1, 1);
    tbl[15] = V(0, 0, '0,   1, B(2), 0, 0, '0,   '0,   1, 1);
    tbl[16] = V(0, 0, '0,   0, '0,   0, 1, A(2), B(2), 1, 1);
    tbl[17] = V(1, 0, '0,   0, '0,   1, 0, '0,   '0,   0, 0);
    tbl[18] = V(0, 0, '0,   0, '0,   1, 0, '0,   '0,   1, 1);
    tbl[19] = V(0, 1, A(6), 0, '0,   1, 0, '0,   '0,   1, 1);
    tbl[20] = V(0, 0, '0,   1, B(6), 1, 0, '0,   '0,   1, 1);
    tbl[21] = V(0, 0, '0,   0, '0,   1, 1, A(6), B(6), 1, 1);
    tbl[22] = V(0, 0, '0,   0, '0,   1, 0, '0,   '0,   1, 1);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].r, tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].ordy);
      check($sformatf("row%0d ovalid", i),     W'(ovalid),     W'(tbl[i].e_ov));
      check($sformatf("row%0d iready_in1", i), W'(iready_in1), W'(tbl[i].e_ir1));
      check($sformatf("row%0d iready_in2", i), W'(iready_in2), W'(tbl[i].e_ir2));
      check($sformatf("row%0d out1", i),       out1,           tbl[i].e_o1);
      check($sformatf("row%0d out2", i),       out2,           tbl[i].e_o2);
    end

    // Scoreboard phases start from a clean reset.
    for (int i = 0; i < 3; i++) mcycle("reset", 1, 0, '0, 0, '0, 0);
    for (int i = 0; i < 2; i++) mcycle("idle", 0, 0, '0, 0, '0, 0);

    npairs = 0;
    for (int k = 0; k < 16; k++) mcycle("aligned", 0, 1, A(k), 1, B(k), 1);
    mcycle("aligned tail", 0, 0, '0, 0, '0, 1);
    mcycle("aligned tail", 0, 0, '0, 0, '0, 1);
    check("aligned pair count", W'(npairs), W'(16));

    for (int k = 0; k < 4; k++) mcycle("bp fill", 0, 1, A(32 + k), 1, B(32 + k), 0);
    for (int k = 0; k < 6; k++) mcycle("bp hold", 0, 1, A(40 + k), 1, B(40 + k), 0);
    npairs = 0;
    for (int k = 0; k < 4; k++) mcycle("bp drain", 0, 0, '0, 0, '0, 1);
    check("bp drained pairs", W'(npairs), W'(4));
    mcycle("bp empty", 0, 0, '0, 0, '0, 1);

    for (int c = 0; c < 1000; c++) begin
      logic         v1, v2, ordy, r;
      logic [W-1:0] d1, d2;
      v1   = ($urandom_range(99, 0) < 65);
      v2   = ($urandom_range(99, 0) < 65);
      ordy = ($urandom_range(99, 0) < 60);
      r    = (c == 500);
      d1   = {2'($urandom_range(3, 0)), 32'($urandom)};
      d2   = {2'($urandom_range(3, 0)), 32'($urandom)};
      mcycle("random", r, v1, d1, v2, d2, ordy);
    end
    for (int k = 0; k < 6; k++) mcycle("final drain", 0, 0, '0, 0, '0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
